// File: rtl/led_pwm_periph.sv
// Memory-mapped 4-channel PWM LED controller on the core data bus.
// Shadowed duty cycles reload only at period wrap, so outputs never glitch mid-period.
module led_pwm_periph #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter logic [15:0] PRESCALE_RST = 16'd46,
  parameter logic        ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  logic [31:0] duty;
  logic [15:0] prescale;
  logic        en;
  logic        inv;
  logic [15:0] psc_cnt;
  logic [7:0]  pwm_cnt;
  logic [31:0] shadow_duty;
  logic [3:0]  pwm_q;

  logic        wr_hit;
  logic        rd_hit;
  logic [1:0]  wr_sel;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] wmask;
  logic [31:0] duty_nxt;
  logic [15:0] psc_nxt;
  logic [31:0] rd_word;
  logic [3:0]  ch_on;
  logic        unused_rd_lsb;

  assign wr_hit = write_mem && (write_address[31:4] == BASE_ADDR[31:4]);
  assign rd_hit = (read_address[31:4] == BASE_ADDR[31:4]);
  assign wr_sel = write_address[3:2];
  assign unused_rd_lsb = &{1'b0, read_address[1:0]};

  // Misaligned or unsupported stores leave be at zero, so they simply vanish.
  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    case (funct3)
      3'b000: begin
        be    = 4'b0001 << write_address[1:0];
        wdata = {4{write_data[7:0]}};
      end
      3'b001: begin
        if (!write_address[0]) begin
          be    = write_address[1] ? 4'b1100 : 4'b0011;
          wdata = {2{write_data[15:0]}};
        end
      end
      3'b010: begin
        if (write_address[1:0] == 2'b00) begin
          be    = 4'b1111;
          wdata = write_data;
        end
      end
      default: begin
        be    = 4'b0000;
        wdata = 32'h0;
      end
    endcase
  end

  assign wmask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign duty_nxt = (duty & ~wmask) | (wdata & wmask);
  assign psc_nxt  = (prescale & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty     <= 32'h0;
      prescale <= PRESCALE_RST;
      en       <= 1'b0;
      inv      <= 1'b0;
    end else if (wr_hit) begin
      case (wr_sel)
        2'd0: duty <= duty_nxt;
        2'd1: prescale <= psc_nxt;
        2'd2: begin
          if (be[0]) begin
            en  <= wdata[0];
            inv <= wdata[1];
          end
        end
        default: ;
      endcase
    end
  end

  // While disabled the shadow tracks DUTY, so enabling starts a period with current duties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt     <= 16'h0;
      pwm_cnt     <= 8'h0;
      shadow_duty <= 32'h0;
    end else if (!en) begin
      psc_cnt     <= 16'h0;
      pwm_cnt     <= 8'h0;
      shadow_duty <= duty;
    end else if (psc_cnt >= prescale) begin
      psc_cnt <= 16'h0;
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) shadow_duty <= duty;
    end else begin
      psc_cnt <= psc_cnt + 16'd1;
    end
  end

  always_comb begin
    ch_on = 4'b0000;
    for (int ch = 0; ch < 4; ch++) begin
      ch_on[ch] = en && (pwm_cnt < shadow_duty[8*ch +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= {4{ACTIVE_LOW}};
    else        pwm_q <= ch_on ^ {4{inv ^ ACTIVE_LOW}};
  end

  assign red   = pwm_q[0];
  assign green = pwm_q[1];
  assign blue  = pwm_q[2];
  assign led   = pwm_q[3];

  always_comb begin
    rd_word = 32'h0;
    case (read_address[3:2])
      2'd0: rd_word = duty;
      2'd1: rd_word = {16'h0, prescale};
      2'd2: rd_word = {30'h0, inv, en};
      2'd3: rd_word = {24'h0, pwm_cnt};
      default: rd_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      read_data <= 32'h0;
    else if (rd_hit) read_data <= rd_word;
    else             read_data <= 32'h0;
  end

endmodule

// File: tb/tb_led_pwm_periph.sv
// Bench for led_pwm_periph: directed bus accesses, randomized stores and PWM runs
// compared against a register-map / period-arithmetic reference model.
module tb_led_pwm_periph;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        write_mem = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] write_address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_address = 32'h0;
  logic [31:0] read_data;
  logic        led, red, green, blue;

  int n_err = 0;
  int n_checks = 0;
  int win [4];
  logic [31:0] m_reg [3];

  led_pwm_periph dut (
    .clk(clk), .rst_n(rst_n), .write_mem(write_mem), .funct3(funct3),
    .write_address(write_address), .write_data(write_data),
    .read_address(read_address), .read_data(read_data),
    .led(led), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] outs();
    return {28'h0, led, blue, green, red};
  endfunction

  // Reference register map: byte-by-byte store semantics.
  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    int nbytes, lane, off;
    logic [31:0] tmp;
    if ((addr >> 4) != (BASE >> 4)) return;
    nbytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    if (nbytes == 0) return;
    lane = int'(addr % 4);
    if (lane % nbytes != 0) return;
    off = int'((addr % 16) / 4);
    if (off == 3) return;
    tmp = m_reg[off];
    for (int i = 0; i < nbytes; i++) tmp[8*(lane+i) +: 8] = data[8*i +: 8];
    if (off == 1) tmp = tmp & 32'h0000_FFFF;
    if (off == 2) tmp = tmp & 32'h0000_0003;
    m_reg[off] = tmp;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    write_mem = 1'b1; funct3 = f3; write_address = addr; write_data = data;
    cyc();
    write_mem = 1'b0;
    model_store(f3, addr, data);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_v);
    read_address = addr;
    cyc();
    chk(tag, read_data, exp_v);
  endtask

  // PWM reference: after the enable edge, k edges later the counter has seen k/(p+1) ticks;
  // a new duty snapshot is taken whenever that tick total reaches a multiple of 256.
  task automatic pwm_run(input int p, input int n, input int wr_k, input logic [31:0] wr_data);
    logic [31:0] shadow_m;
    logic [31:0] duty_pre;
    logic [3:0]  exp_o;
    logic [7:0]  sh;
    int prev_total, total, cnt_prev, period;
    shadow_m = m_reg[0];
    prev_total = 0;
    for (int j = 0; j < 4; j++) win[j] = 0;
    for (int k = 1; k <= n; k++) begin
      read_address = (k == 1) ? BASE + 32'h8 : BASE + 32'hC;
      duty_pre = m_reg[0];
      if (k == wr_k) begin
        write_mem = 1'b1; funct3 = 3'b010; write_address = BASE; write_data = wr_data;
      end
      cyc();
      if (k == wr_k) begin
        write_mem = 1'b0;
        model_store(3'b010, BASE, wr_data);
      end
      cnt_prev = prev_total % 256;
      for (int ch = 0; ch < 4; ch++) begin
        sh = shadow_m[8*ch +: 8];
        exp_o[ch] = (cnt_prev < int'(sh)) ^ m_reg[2][1] ^ 1'b1;
      end
      chk("pwm_out", outs(), {28'h0, exp_o});
      if (k == 1) chk("ctrl_after_write", read_data, m_reg[2]);
      else        chk("pwm_count", read_data, cnt_prev);
      period = prev_total / 256;
      if (period < 4 && red == 1'b0) win[period]++;
      total = k / (p + 1);
      if (total != prev_total && total % 256 == 0) shadow_m = duty_pre;
      prev_total = total;
    end
  endtask

  initial begin
    logic [31:0] d, a, g;
    logic [2:0]  f3;
    int off, p;

    m_reg[0] = 32'h0; m_reg[1] = 32'h2E; m_reg[2] = 32'h0;

    #2 rst_n = 1'b0;
    #1 chk("reset_outs_async", outs(), 32'hF);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 32'hF);
    chk("reset_read_data", read_data, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    rd_chk("rst_prescale", BASE + 32'h4, 32'h0000_002E);
    rd_chk("rst_duty", BASE, 32'h0);
    rd_chk("rst_ctrl", BASE + 32'h8, 32'h0);
    rd_chk("rst_count", BASE + 32'hC, 32'h0);

    store(3'b010, BASE, 32'h40C0_8010);
    store(3'b000, BASE + 32'h1, 32'h0000_00FF);
    rd_chk("sw_sb_duty", BASE, 32'h40C0_FF10);
    store(3'b001, BASE + 32'h1, 32'h0000_1234);
    rd_chk("sh_misaligned_dropped", BASE, 32'h40C0_FF10);
    store(3'b010, 32'hFFFF_FE00, 32'hDEAD_BEEF);
    rd_chk("nonhit_store", BASE, 32'h40C0_FF10);
    rd_chk("read_0x10", BASE + 32'h10, 32'h0);
    rd_chk("read_nonhit", 32'hFFFF_FEFC, 32'h0);
    store(3'b011, BASE, 32'h1111_1111);
    rd_chk("bad_funct3_dropped", BASE, 32'h40C0_FF10);

    for (int i = 0; i < 60; i++) begin
      f3  = 3'($urandom_range(0, 4));
      off = $urandom_range(0, 15);
      a   = ($urandom_range(0, 7) == 0) ? BASE - 32'(16 * $urandom_range(1, 4)) + 32'(off)
                                        : BASE + 32'(off);
      d   = $urandom;
      store(f3, a, d);
      off = $urandom_range(0, 2);
      rd_chk("rand_readback", BASE + 32'(4 * off), m_reg[off]);
    end

    store(3'b010, BASE + 32'h8, 32'h0);
    store(3'b010, BASE + 32'h4, 32'h0);
    g = 32'($urandom_range(0, 255));
    store(3'b010, BASE, {8'hFF, 8'h00, g[7:0], 8'h40});
    cyc();

    // Enable and read CTRL in the same cycle: the read sees the old value.
    write_mem = 1'b1; funct3 = 3'b010; write_address = BASE + 32'h8; write_data = 32'h1;
    read_address = BASE + 32'h8;
    cyc();
    write_mem = 1'b0;
    chk("same_cycle_read", read_data, m_reg[2]);
    model_store(3'b010, BASE + 32'h8, 32'h1);
    chk("outs_at_enable_edge", outs(), 32'hF);
    d = $urandom;
    pwm_run(0, 780, 300, {d[31:8], 8'h80});
    chk("red_width_p0", win[0], 64);
    chk("red_width_p1", win[1], 64);
    chk("red_width_after_wrap", win[2], 128);

    write_mem = 1'b1; funct3 = 3'b010; write_address = BASE + 32'h8; write_data = 32'h0;
    cyc();
    write_mem = 1'b0;
    model_store(3'b010, BASE + 32'h8, 32'h0);
    cyc();
    chk("disable_outs_off", outs(), 32'hF);
    rd_chk("disable_count_zero", BASE + 32'hC, 32'h0);
    store(3'b010, BASE + 32'h8, 32'h2);
    cyc();
    chk("inv_disabled_outs", outs(), 32'h0);
    store(3'b010, BASE + 32'h8, 32'h0);
    cyc();

    p = $urandom_range(1, 3);
    store(3'b010, BASE + 32'h4, 32'(p));
    d = $urandom;
    store(3'b010, BASE, {8'hFF, d[23:0]});
    store(3'b010, BASE + 32'h8, 32'h1);
    d = $urandom;
    pwm_run(p, 256 * (p + 1) + 40, 200, {8'hFF, d[23:0]});

    #3 rst_n = 1'b0;
    #1;
    chk("midperiod_reset_outs", outs(), 32'hF);
    chk("midperiod_reset_rdata", read_data, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    m_reg[0] = 32'h0; m_reg[1] = 32'h2E; m_reg[2] = 32'h0;
    rd_chk("rst2_duty", BASE, m_reg[0]);
    rd_chk("rst2_prescale", BASE + 32'h4, m_reg[1]);
    rd_chk("rst2_ctrl", BASE + 32'h8, m_reg[2]);
    rd_chk("rst2_count", BASE + 32'hC, 32'h0);
    chk("rst2_outs", outs(), 32'hF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
